// File: rtl/multicycle_control_unit.sv
// Control FSM for the shared multicycle RV32I datapath: sequences one ALU, ALUOut,
// and a unified memory port across IF/ID/EX/MEM/WB plus PC-update and halt states.
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | fetch: request memory at PC, load IR on mem_ready
// ID    | decode: ALUOut <= PC+4, dispatch on opcode
// EX    | execute: address, ALU result, branch compare or jump
// MEM   | data access at ALUOut, hold until mem_ready
// WB    | write rd (ALUOut or MDR) and PC <= PC+4
// PCINC | PC <= PC+4 only
// BRT   | branch taken: PC <= PC+imm
// HALT  | stopped until reset

module multicycle_control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       ecall_halt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_source,
  output logic       aluout_we,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_PCINC = 3'd5,
    S_BRT   = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t state_q, state_d;
  logic   known_op;

  assign known_op = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                    (opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                    (opcode == OP_JAL) || (opcode == OP_JALR);
  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (opcode == OP_ECALL) state_d = ecall_halt ? S_HALT : S_PCINC;
        else if (known_op)      state_d = S_EX;
        else                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_PCINC;
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I:         state_d = S_WB;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH:          state_d = bcond ? S_BRT : S_PCINC;
          OP_JAL, OP_JALR:    state_d = S_IF;
          default:            state_d = S_PCINC;
        endcase
      end
      S_MEM: if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_PCINC;
      S_WB, S_PCINC, S_BRT: state_d = S_IF;
      default:              state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    aluout_we  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op_sel = 2'b00;
    halted     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_ID: begin
        aluout_we = 1'b1;
        alu_src_b = 2'b01;
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1; alu_op_sel = 2'b01; aluout_we = 1'b1;
          end
          OP_I: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op_sel = 2'b01; aluout_we = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; aluout_we = 1'b1;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1; alu_op_sel = 2'b10;
          end
          OP_JAL, OP_JALR: begin
            // rd takes PC+4 from ALUOut while the ALU forms the jump target
            alu_src_a = (opcode == OP_JALR);
            alu_src_b = 2'b10;
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
      end
      S_PCINC: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_BRT: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: halted = 1'b1;
    endcase
    // Reset kills outputs combinationally so an in-flight store never writes
    if (!reset_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 1'b0;
      aluout_we  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op_sel = 2'b00;
      halted     = 1'b0;
    end
  end

endmodule
